// File: rtl/phase_ctrl_pkg.sv
// Shared types and default widths for the multi-channel phase sweep controller.
package phase_ctrl_pkg;

    localparam int unsigned DefNCh         = 4;
    localparam int unsigned DefPwmCntWidth = 24;
    localparam int unsigned DefStepWidth   = 16;
    localparam int unsigned DefCntWidth    = 8;
    localparam int unsigned ModeWidth      = 4;

    typedef enum logic [ModeWidth-1:0] {
        ModeOff      = 4'd0,
        ModeFull     = 4'd1,
        ModePingpong = 4'd2,
        ModeRamp     = 4'd3
    } phase_mode_t;

    typedef enum logic [1:0] {
        StIdle,
        StPrepare,
        StRun
    } phase_state_t;

endpackage

// File: rtl/phase_sweep_ch.sv
// One phase sweep channel: start/stop FSM, PWM edge detect with skip, and the
// FULL / PINGPONG / RAMP phase stepping datapath.
module phase_sweep_ch
    import phase_ctrl_pkg::*;
#(
    parameter int unsigned PWM_CNT_WIDTH = DefPwmCntWidth,
    parameter int unsigned STEP_WIDTH    = DefStepWidth,
    parameter int unsigned CNT_WIDTH     = DefCntWidth
) (
    input  logic                     axi_clk,
    input  logic                     axi_rst,
    input  logic                     en_i,
    input  logic                     edge_sel_i,
    input  logic [ModeWidth-1:0]     mode_i,
    input  logic [CNT_WIDTH-1:0]     cnt_i,
    input  logic [CNT_WIDTH-1:0]     skip_cnt_i,
    input  logic [STEP_WIDTH-1:0]    step_i,
    input  logic [PWM_CNT_WIDTH-1:0] start_i,
    input  logic [PWM_CNT_WIDTH-1:0] lo_i,
    input  logic [PWM_CNT_WIDTH-1:0] hi_i,
    input  logic [PWM_CNT_WIDTH-1:0] period_i,
    input  logic                     pwm_sig_i,
    output logic                     ch_en_o,
    output logic [PWM_CNT_WIDTH-1:0] cur_phase_o,
    output logic                     done_o
);
    localparam int unsigned CW = PWM_CNT_WIDTH + 2;

    phase_state_t             state_q;
    logic                     en_d_q, pwm_d_q, dir_q, half_q, ch_en_q, done_q;
    logic [PWM_CNT_WIDTH-1:0] cur_q;
    logic [PWM_CNT_WIDTH:0]   dist_q;
    logic [CNT_WIDTH-1:0]     cnt_q, skip_q;

    logic signed [CW-1:0] cur_s, step_s, abs_s, lo_s, hi_s, p_s, per_s, dist_s;
    logic signed [CW-1:0] nxt_s, dist_nxt;
    logic                 nxt_dir, nxt_half, cnt_dec, ramp_end, rev;
    logic                 pwm_edge, mode_valid, term;
    logic                 unused_bits;

    assign cur_s  = $signed({2'b00, cur_q});
    assign step_s = $signed({{(CW-STEP_WIDTH){step_i[STEP_WIDTH-1]}}, step_i});
    assign abs_s  = step_s[CW-1] ? -step_s : step_s;
    assign lo_s   = $signed({2'b00, lo_i});
    assign hi_s   = $signed({2'b00, hi_i});
    assign p_s    = $signed({2'b00, period_i});
    assign per_s  = p_s + $signed(CW'(1));
    assign dist_s = $signed({1'b0, dist_q});

    assign pwm_edge   = edge_sel_i ? (pwm_sig_i & ~pwm_d_q) : (~pwm_sig_i & pwm_d_q);
    assign mode_valid = mode_i inside {ModeFull, ModePingpong, ModeRamp};
    assign term       = ramp_end | (cnt_dec & (cnt_q == CNT_WIDTH'(1)) & (cnt_i != '0));

    assign unused_bits = ^{nxt_s[CW-1 -: 2], dist_nxt[CW-1]};

    always_comb begin
        nxt_s    = cur_s;
        dist_nxt = dist_s;
        nxt_dir  = dir_q;
        nxt_half = half_q;
        cnt_dec  = 1'b0;
        ramp_end = 1'b0;
        rev      = 1'b0;
        case (mode_i)
            ModeFull: begin
                nxt_s = cur_s + step_s;
                if (nxt_s > p_s) begin
                    nxt_s = nxt_s - per_s;
                end else if (nxt_s[CW-1]) begin
                    nxt_s = nxt_s + per_s;
                end
                // Travelled distance counts whole periods independent of direction.
                dist_nxt = dist_s + abs_s;
                if (dist_nxt >= per_s) begin
                    dist_nxt = dist_nxt - per_s;
                    cnt_dec  = 1'b1;
                end
            end
            ModePingpong: begin
                if (dir_q) begin
                    nxt_s = cur_s - abs_s;
                    if (nxt_s <= lo_s) begin
                        nxt_s = lo_s;
                        rev   = 1'b1;
                    end
                end else begin
                    nxt_s = cur_s + abs_s;
                    if (nxt_s >= hi_s) begin
                        nxt_s = hi_s;
                        rev   = 1'b1;
                    end
                end
                if (rev) begin
                    nxt_dir  = ~dir_q;
                    nxt_half = ~half_q;
                    cnt_dec  = half_q;
                end
            end
            ModeRamp: begin
                if (cur_s <= hi_s) begin
                    nxt_s = cur_s + abs_s;
                    if (nxt_s >= hi_s) begin
                        nxt_s    = hi_s;
                        ramp_end = 1'b1;
                    end
                end else begin
                    nxt_s = cur_s - abs_s;
                    if (nxt_s <= hi_s) begin
                        nxt_s    = hi_s;
                        ramp_end = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            state_q <= StIdle;
            en_d_q  <= 1'b0;
            pwm_d_q <= 1'b0;
            dir_q   <= 1'b0;
            half_q  <= 1'b0;
            ch_en_q <= 1'b0;
            done_q  <= 1'b0;
            cur_q   <= '0;
            dist_q  <= '0;
            cnt_q   <= '0;
            skip_q  <= '0;
        end else begin
            en_d_q  <= en_i;
            pwm_d_q <= pwm_sig_i;
            done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (en_i && !en_d_q && (mode_i != ModeOff)) begin
                        cur_q   <= start_i;
                        cnt_q   <= cnt_i;
                        skip_q  <= skip_cnt_i;
                        dist_q  <= '0;
                        dir_q   <= step_i[STEP_WIDTH-1];
                        half_q  <= 1'b0;
                        ch_en_q <= 1'b1;
                        state_q <= StPrepare;
                    end
                end
                StPrepare: begin
                    if (en_i && mode_valid) begin
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                        ch_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                StRun: begin
                    // Disable beats a coincident PWM edge: no step is taken.
                    if (!en_i) begin
                        state_q <= StIdle;
                        ch_en_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (pwm_edge) begin
                        if (skip_q == '0) begin
                            skip_q <= skip_cnt_i;
                            cur_q  <= nxt_s[PWM_CNT_WIDTH-1:0];
                            dist_q <= dist_nxt[PWM_CNT_WIDTH:0];
                            dir_q  <= nxt_dir;
                            half_q <= nxt_half;
                            if (cnt_dec && (cnt_q != '0)) begin
                                cnt_q <= cnt_q - CNT_WIDTH'(1);
                            end
                            if (term) begin
                                state_q <= StIdle;
                                ch_en_q <= 1'b0;
                                done_q  <= 1'b1;
                            end
                        end else begin
                            skip_q <= skip_q - CNT_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign ch_en_o     = ch_en_q;
    assign cur_phase_o = cur_q;
    assign done_o      = done_q;

endmodule

// File: rtl/phase_sweep_ctrl.sv
// Multi-channel phase sweep controller: N_CH independent phase_sweep_ch
// instances sharing a global engine enable.
module phase_sweep_ctrl
    import phase_ctrl_pkg::*;
#(
    parameter int unsigned N_CH          = DefNCh,
    parameter int unsigned PWM_CNT_WIDTH = DefPwmCntWidth,
    parameter int unsigned STEP_WIDTH    = DefStepWidth,
    parameter int unsigned CNT_WIDTH     = DefCntWidth
) (
    input  logic                     axi_clk,
    input  logic                     axi_rst,
    input  logic                     phase_ctrl_en_i,
    input  logic                     phase_ch_en_i     [N_CH],
    input  logic                     phase_edge_i      [N_CH],
    input  logic [ModeWidth-1:0]     phase_mode_i      [N_CH],
    input  logic [CNT_WIDTH-1:0]     phase_cnt_i       [N_CH],
    input  logic [CNT_WIDTH-1:0]     phase_skip_cnt_i  [N_CH],
    input  logic [STEP_WIDTH-1:0]    phase_step_i      [N_CH],
    input  logic [PWM_CNT_WIDTH-1:0] phase_start_i     [N_CH],
    input  logic [PWM_CNT_WIDTH-1:0] phase_lo_i        [N_CH],
    input  logic [PWM_CNT_WIDTH-1:0] phase_hi_i        [N_CH],
    input  logic [PWM_CNT_WIDTH-1:0] pwm_period_i      [N_CH],
    input  logic                     pwm_sig_i         [N_CH],
    output logic                     phase_ch_en_o     [N_CH],
    output logic [PWM_CNT_WIDTH-1:0] phase_cur_phase_o [N_CH],
    output logic                     phase_done_o      [N_CH]
);
    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        phase_sweep_ch #(
            .PWM_CNT_WIDTH (PWM_CNT_WIDTH),
            .STEP_WIDTH    (STEP_WIDTH),
            .CNT_WIDTH     (CNT_WIDTH)
        ) u_ch (
            .axi_clk     (axi_clk),
            .axi_rst     (axi_rst),
            .en_i        (phase_ctrl_en_i & phase_ch_en_i[g]),
            .edge_sel_i  (phase_edge_i[g]),
            .mode_i      (phase_mode_i[g]),
            .cnt_i       (phase_cnt_i[g]),
            .skip_cnt_i  (phase_skip_cnt_i[g]),
            .step_i      (phase_step_i[g]),
            .start_i     (phase_start_i[g]),
            .lo_i        (phase_lo_i[g]),
            .hi_i        (phase_hi_i[g]),
            .period_i    (pwm_period_i[g]),
            .pwm_sig_i   (pwm_sig_i[g]),
            .ch_en_o     (phase_ch_en_o[g]),
            .cur_phase_o (phase_cur_phase_o[g]),
            .done_o      (phase_done_o[g])
        );
    end

endmodule

// File: tb/tb_phase_sweep_ctrl.sv
// Directed bench for phase_sweep_ctrl: hand-computed phase sequences per mode.
module tb_phase_sweep_ctrl;
    localparam int unsigned NCh = 4;

    logic        axi_clk = 1'b0;
    logic        axi_rst;
    logic        phase_ctrl_en_i;
    logic        phase_ch_en_i     [NCh];
    logic        phase_edge_i      [NCh];
    logic [3:0]  phase_mode_i      [NCh];
    logic [7:0]  phase_cnt_i       [NCh];
    logic [7:0]  phase_skip_cnt_i  [NCh];
    logic [15:0] phase_step_i      [NCh];
    logic [23:0] phase_start_i     [NCh];
    logic [23:0] phase_lo_i        [NCh];
    logic [23:0] phase_hi_i        [NCh];
    logic [23:0] pwm_period_i      [NCh];
    logic        pwm_sig_i         [NCh];
    logic        phase_ch_en_o     [NCh];
    logic [23:0] phase_cur_phase_o [NCh];
    logic        phase_done_o      [NCh];

    int checks = 0;
    int errors = 0;

    always #5 axi_clk = ~axi_clk;

    phase_sweep_ctrl u_dut (
        .axi_clk           (axi_clk),
        .axi_rst           (axi_rst),
        .phase_ctrl_en_i   (phase_ctrl_en_i),
        .phase_ch_en_i     (phase_ch_en_i),
        .phase_edge_i      (phase_edge_i),
        .phase_mode_i      (phase_mode_i),
        .phase_cnt_i       (phase_cnt_i),
        .phase_skip_cnt_i  (phase_skip_cnt_i),
        .phase_step_i      (phase_step_i),
        .phase_start_i     (phase_start_i),
        .phase_lo_i        (phase_lo_i),
        .phase_hi_i        (phase_hi_i),
        .pwm_period_i      (pwm_period_i),
        .pwm_sig_i         (pwm_sig_i),
        .phase_ch_en_o     (phase_ch_en_o),
        .phase_cur_phase_o (phase_cur_phase_o),
        .phase_done_o      (phase_done_o)
    );

    task automatic tick();
        @(posedge axi_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ch(input int ch, input string tag, input logic en, input logic done,
                          input logic [31:0] cur);
        chk($sformatf("%s ch%0d ch_en", tag, ch), 32'(phase_ch_en_o[ch]), 32'(en));
        chk($sformatf("%s ch%0d done", tag, ch), 32'(phase_done_o[ch]), 32'(done));
        chk($sformatf("%s ch%0d cur", tag, ch), 32'(phase_cur_phase_o[ch]), cur);
    endtask

    task automatic cfg(input int ch, input logic [3:0] mode, input logic edge_rise,
                       input logic [7:0] cnt, input logic [7:0] skip, input logic [15:0] step,
                       input logic [23:0] start, input logic [23:0] lo, input logic [23:0] hi,
                       input logic [23:0] per);
        phase_mode_i[ch]     = mode;
        phase_edge_i[ch]     = edge_rise;
        phase_cnt_i[ch]      = cnt;
        phase_skip_cnt_i[ch] = skip;
        phase_step_i[ch]     = step;
        phase_start_i[ch]    = start;
        phase_lo_i[ch]       = lo;
        phase_hi_i[ch]       = hi;
        pwm_period_i[ch]     = per;
    endtask

    task automatic pwm_set(input logic [NCh-1:0] mask, input logic v);
        for (int i = 0; i < NCh; i++) begin
            if (mask[i]) pwm_sig_i[i] = v;
        end
    endtask

    int full_exp [7]  = '{40, 70, 0, 30, 60, 90, 20};
    int cont_exp [6]  = '{75, 50, 25, 0, 75, 50};
    int pp_exp   [5]  = '{45, 50, 35, 20, 10};
    int ramp_exp [9]  = '{0, 0, 8, 8, 8, 16, 16, 16, 20};
    int conc0    [3]  = '{40, 80, 20};
    int conc1    [3]  = '{80, 100, 70};

    initial begin
        axi_rst         = 1'b1;
        phase_ctrl_en_i = 1'b0;
        for (int i = 0; i < NCh; i++) begin
            phase_ch_en_i[i] = 1'b0;
            pwm_sig_i[i]     = 1'b0;
            cfg(i, 4'd0, 1'b1, 8'd0, 8'd0, 16'd0, 24'd0, 24'd0, 24'd0, 24'd0);
        end
        tick();
        tick();
        for (int i = 0; i < NCh; i++) chk_ch(i, "reset", 1'b0, 1'b0, 0);
        axi_rst         = 1'b0;
        phase_ctrl_en_i = 1'b1;
        tick();

        // FULL with wrap, two periods of travel
        cfg(0, 4'd1, 1'b1, 8'd2, 8'd0, 16'd30, 24'd10, 24'd0, 24'd99, 24'd99);
        phase_ch_en_i[0] = 1'b1;
        tick();
        chk_ch(0, "full_prep", 1'b1, 1'b0, 10);
        tick();
        chk_ch(0, "full_run", 1'b1, 1'b0, 10);
        for (int i = 0; i < 7; i++) begin
            pwm_set(4'b0001, 1'b1);
            tick();
            chk_ch(0, "full_step", (i < 6), (i == 6), full_exp[i]);
            pwm_set(4'b0001, 1'b0);
            tick();
        end
        chk_ch(0, "full_post", 1'b0, 1'b0, 20);
        tick();
        chk_ch(0, "full_norestart", 1'b0, 1'b0, 20);
        phase_ch_en_i[0] = 1'b0;
        tick();

        // FULL continuous, negative step; disable coincides with an edge
        cfg(0, 4'd1, 1'b1, 8'd0, 8'd0, 16'hFFE7, 24'd0, 24'd0, 24'd99, 24'd99);
        phase_ch_en_i[0] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            pwm_set(4'b0001, 1'b1);
            tick();
            chk_ch(0, "cont_step", 1'b1, 1'b0, cont_exp[i]);
            pwm_set(4'b0001, 1'b0);
            tick();
        end
        pwm_set(4'b0001, 1'b1);
        phase_ch_en_i[0] = 1'b0;
        tick();
        chk_ch(0, "dis_edge", 1'b0, 1'b1, 50);
        pwm_set(4'b0001, 1'b0);
        tick();
        chk_ch(0, "dis_after", 1'b0, 1'b0, 50);

        // PINGPONG, one count ends on the second reversal
        cfg(2, 4'd2, 1'b1, 8'd1, 8'd0, 16'd15, 24'd30, 24'd10, 24'd50, 24'd99);
        phase_ch_en_i[2] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            pwm_set(4'b0100, 1'b1);
            tick();
            chk_ch(2, "pp_step", (i < 4), (i == 4), pp_exp[i]);
            pwm_set(4'b0100, 1'b0);
            tick();
        end
        chk_ch(2, "pp_post", 1'b0, 1'b0, 10);
        phase_ch_en_i[2] = 1'b0;

        // RAMP on falling edges with skip=2
        cfg(3, 4'd3, 1'b0, 8'd0, 8'd2, 16'd8, 24'd0, 24'd0, 24'd20, 24'd99);
        phase_ch_en_i[3] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 9; i++) begin
            pwm_set(4'b1000, 1'b1);
            tick();
            pwm_set(4'b1000, 1'b0);
            tick();
            chk_ch(3, "ramp_fall", (i < 8), (i == 8), ramp_exp[i]);
        end
        phase_ch_en_i[3] = 1'b0;
        tick();

        // Two channels concurrently in different modes
        cfg(0, 4'd1, 1'b1, 8'd0, 8'd0, 16'd40, 24'd0, 24'd0, 24'd99, 24'd99);
        cfg(1, 4'd2, 1'b1, 8'd0, 8'd0, 16'd30, 24'd50, 24'd0, 24'd100, 24'd199);
        phase_ch_en_i[0] = 1'b1;
        phase_ch_en_i[1] = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            pwm_set(4'b0011, 1'b1);
            tick();
            chk_ch(0, "conc_full", 1'b1, 1'b0, conc0[i]);
            chk_ch(1, "conc_pp", 1'b1, 1'b0, conc1[i]);
            pwm_set(4'b0011, 1'b0);
            tick();
        end
        chk_ch(2, "conc_idle", 1'b0, 1'b0, 10);
        phase_ch_en_i[0] = 1'b0;
        phase_ch_en_i[1] = 1'b0;
        tick();
        chk_ch(0, "conc_dis", 1'b0, 1'b1, 20);
        chk_ch(1, "conc_dis", 1'b0, 1'b1, 70);
        tick();

        // Invalid mode: done two clocks after the enable edge
        cfg(3, 4'd5, 1'b1, 8'd0, 8'd0, 16'd8, 24'd33, 24'd0, 24'd50, 24'd99);
        phase_ch_en_i[3] = 1'b1;
        tick();
        chk_ch(3, "inv_prep", 1'b1, 1'b0, 33);
        tick();
        chk_ch(3, "inv_done", 1'b0, 1'b1, 33);
        tick();
        chk_ch(3, "inv_post", 1'b0, 1'b0, 33);
        phase_ch_en_i[3] = 1'b0;
        tick();

        // Mode 0 start stays idle
        cfg(3, 4'd0, 1'b1, 8'd0, 8'd0, 16'd8, 24'd7, 24'd0, 24'd50, 24'd99);
        phase_ch_en_i[3] = 1'b1;
        tick();
        chk_ch(3, "off_start", 1'b0, 1'b0, 33);
        tick();
        chk_ch(3, "off_hold", 1'b0, 1'b0, 33);
        phase_ch_en_i[3] = 1'b0;
        tick();

        // Reset in the middle of a run
        cfg(0, 4'd1, 1'b1, 8'd0, 8'd0, 16'd30, 24'd10, 24'd0, 24'd99, 24'd99);
        phase_ch_en_i[0] = 1'b1;
        tick();
        tick();
        pwm_set(4'b0001, 1'b1);
        tick();
        chk_ch(0, "pre_rst", 1'b1, 1'b0, 40);
        pwm_set(4'b0001, 1'b0);
        tick();
        axi_rst = 1'b1;
        tick();
        chk_ch(0, "mid_rst", 1'b0, 1'b0, 0);
        chk_ch(1, "mid_rst", 1'b0, 1'b0, 0);
        phase_ch_en_i[0] = 1'b0;
        axi_rst          = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
